// File: rtl/gvt_commit_unit.sv
// gvt_commit_unit: buffers processed-event history records in push order and
// retires each one to the writeback path once its timestamp is strictly below
// GVT. It raises a sticky done flag once GVT reaches end_time with all history
// drained.
//
// Optional build macro GVT_COMMIT_STATS_EN adds the commit_cnt and stall_cnt
// saturating statistics outputs.
//
// state  | meaning
// IDLE   | output register empty (out_vld = 0), waiting for a committable head
// COMMIT | output register holds a record presented to writeback (out_vld = 1)
// DONE   | simulation complete; input closed, left only through rst_n
module gvt_commit_unit #(
   parameter int TIME_WID = 16,
   parameter int DATA_WID = 32,
   parameter int DEPTH    = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [TIME_WID-1:0]       gvt,
   input  logic [TIME_WID-1:0]       end_time,
   input  logic                      in_vld,
   output logic                      in_rdy,
   input  logic [TIME_WID-1:0]       in_time,
   input  logic [DATA_WID-1:0]       in_data,
   output logic                      out_vld,
   input  logic                      out_rdy,
   output logic [TIME_WID-1:0]       out_time,
   output logic [DATA_WID-1:0]       out_data,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      done
`ifdef GVT_COMMIT_STATS_EN
   ,
   output logic [31:0]               commit_cnt,
   output logic [31:0]               stall_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COMMIT = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [TIME_WID-1:0] mem_time [DEPTH];
   logic [DATA_WID-1:0] mem_data [DEPTH];
   logic [AW-1:0]       head, tail;
   logic [TIME_WID-1:0] head_time;
   logic                push, load, hshk, reg_free;

   // Only the head entry is ever considered for retirement, which keeps
   // commits in strict push order.
   always_comb begin
      head_time = mem_time[head];
      push      = in_vld && in_rdy;
      hshk      = out_vld && out_rdy;
      reg_free  = !out_vld || out_rdy;
      load      = reg_free && (count != '0) && (head_time < gvt);
   end

   // State register; an async reset drops a pending out_vld immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (load)
               state_nxt = COMMIT;
            else if ((gvt >= end_time) && (count == '0) && !in_vld)
               state_nxt = DONE;
         end
         COMMIT: begin
            if (hshk && !load) state_nxt = IDLE;
         end
         DONE:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // State-decoded outputs; no bypass, so a full buffer refuses input even
   // when a load frees an entry in the same cycle.
   always_comb begin
      out_vld = (state == COMMIT);
      done    = (state == DONE);
      in_rdy  = (count < DEPTH_C) && (state != DONE);
   end

   // History storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_time[tail] <= in_time;
         mem_data[tail] <= in_data;
      end
   end

   // Pointers and occupancy; a simultaneous push and load leaves count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + AW'(1);
         if (load) head <= head + AW'(1);
         case ({push, load})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Output register: captured only on load, so gvt changes cannot disturb
   // a record that is still being presented.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_time <= '0;
         out_data <= '0;
      end else if (load) begin
         out_time <= head_time;
         out_data <= mem_data[head];
      end
   end

`ifdef GVT_COMMIT_STATS_EN
   logic stall;

   // A stall is a cycle where the output could accept a record but the
   // head is not yet below GVT.
   always_comb begin
      stall = reg_free && (count != '0) && !(head_time < gvt);
   end

   // Saturating statistics counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         commit_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (hshk && (commit_cnt != '1)) commit_cnt <= commit_cnt + 32'd1;
         if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_gvt_commit_unit.sv
// Self-checking bench for gvt_commit_unit: scenario tasks drive stimulus and
// push expected records into a scoreboard; a negedge monitor pops and compares
// every committed record as its handshake is seen.
module tb_gvt_commit_unit;

   localparam int TW = 16;
   localparam int DW = 32;
   localparam int DP = 16;

   typedef struct packed {
      logic [TW-1:0] t;
      logic [DW-1:0] d;
   } rec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [TW-1:0] gvt, end_time, in_time, out_time;
   logic [DW-1:0] in_data, out_data;
   logic          in_vld, in_rdy, out_vld, out_rdy, done;
   logic [4:0]    count;
`ifdef GVT_COMMIT_STATS_EN
   logic [31:0]   commit_cnt, stall_cnt;
`endif

   rec_t sb[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   hs_cnt = 0;

   gvt_commit_unit #(.TIME_WID(TW), .DATA_WID(DW), .DEPTH(DP)) dut (
      .clk(clk), .rst_n(rst_n), .gvt(gvt), .end_time(end_time),
      .in_vld(in_vld), .in_rdy(in_rdy), .in_time(in_time), .in_data(in_data),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_time(out_time), .out_data(out_data),
      .count(count), .done(done)
`ifdef GVT_COMMIT_STATS_EN
      , .commit_cnt(commit_cnt), .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: a handshake seen at negedge completes at the next posedge.
   always @(negedge clk) begin
      if (rst_n && out_vld && out_rdy) begin
         hs_cnt++;
         n_total++;
         if (sb.size() == 0) begin
            $display("FAIL commit_unexpected: got time=%0d data=%h, required no record", out_time, out_data);
         end else begin
            rec_t e;
            e = sb.pop_front();
            if (out_time !== e.t || out_data !== e.d)
               $display("FAIL commit_order: got time=%0d data=%h, required time=%0d data=%h",
                        out_time, out_data, e.t, e.d);
            else
               n_pass++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input logic [TW-1:0] et);
      rst_n = 1'b0; in_vld = 1'b0; in_time = '0; in_data = '0;
      out_rdy = 1'b0; gvt = '0; end_time = et;
      sb.delete();
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic push_rec(input logic [TW-1:0] t, input logic [DW-1:0] d);
      bit ok = 0;
      in_vld = 1'b1; in_time = t; in_data = d;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (in_rdy === 1'b1) begin
            sb.push_back('{t: t, d: d});
            ok = 1;
         end
         tick();
      end
      in_vld = 1'b0;
      if (!ok) begin
         n_total++;
         $display("FAIL push_timeout: in_rdy stayed %b, required 1", in_rdy);
      end
   endtask

   task automatic test_reset();
      apply_reset(16'hFFFF);
      n_total++;
      if (count !== 5'd0 || out_vld !== 1'b0 || done !== 1'b0 || in_rdy !== 1'b1 ||
          out_time !== 16'd0 || out_data !== 32'd0)
         $display("FAIL reset_state: got count=%0d out_vld=%b done=%b in_rdy=%b out_time=%0d out_data=%h, required 0 0 0 1 0 0",
                  count, out_vld, done, in_rdy, out_time, out_data);
      else n_pass++;
   endtask

   task automatic test_basic();
      bit bad = 0;
      apply_reset(16'hFFFF);
      out_rdy = 1'b1;
      push_rec(16'd5, 32'hA);
      n_total++;
      if (count !== 5'd1) $display("FAIL basic_count_push: got %0d, required 1", count);
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         if (out_vld !== 1'b0) bad = 1;
         tick();
      end
      gvt = 16'd5;
      for (int i = 0; i < 4; i++) begin
         if (out_vld !== 1'b0) bad = 1;
         tick();
      end
      n_total++;
      if (bad) $display("FAIL basic_hold: out_vld rose with gvt <= time, required 0");
      else n_pass++;
      gvt = 16'd6;
      tick();
      n_total++;
      if (out_vld !== 1'b1 || out_time !== 16'd5 || out_data !== 32'hA || count !== 5'd0)
         $display("FAIL basic_commit: got vld=%b time=%0d data=%h count=%0d, required 1 5 a 0",
                  out_vld, out_time, out_data, count);
      else n_pass++;
      tick();
   endtask

   task automatic test_fill();
      int hs0;
      apply_reset(16'hFFFF);
      out_rdy = 1'b1;
      for (int i = 1; i <= DP; i++) push_rec(16'(i), 32'h100 + 32'(i));
      n_total++;
      if (count !== 5'd16 || in_rdy !== 1'b0)
         $display("FAIL fill_full: got count=%0d in_rdy=%b, required 16 0", count, in_rdy);
      else n_pass++;
      hs0 = hs_cnt;
      gvt = 16'hFFFF;
      for (int i = 1; i <= DP; i++) begin
         tick();
         n_total++;
         if (out_vld !== 1'b1 || out_time !== 16'(i))
            $display("FAIL fill_stream: cycle %0d got vld=%b time=%0d, required 1 %0d", i, out_vld, out_time, i);
         else n_pass++;
      end
      tick();
      n_total++;
      if (hs_cnt - hs0 !== DP || count !== 5'd0)
         $display("FAIL fill_drain: got handshakes=%0d count=%0d, required 16 0", hs_cnt - hs0, count);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int hs0;
      apply_reset(16'hFFFF);
      gvt = 16'd10;
      push_rec(16'd3, 32'h33);
      tick();
      n_total++;
      if (out_vld !== 1'b1 || out_time !== 16'd3)
         $display("FAIL bp_present: got vld=%b time=%0d, required 1 3", out_vld, out_time);
      else n_pass++;
      gvt = 16'd2;
      tick(); tick(); tick();
      n_total++;
      if (out_vld !== 1'b1 || out_time !== 16'd3 || out_data !== 32'h33)
         $display("FAIL bp_stable: got vld=%b time=%0d data=%h, required 1 3 33", out_vld, out_time, out_data);
      else n_pass++;
      hs0 = hs_cnt;
      out_rdy = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      n_total++;
      if (hs_cnt - hs0 !== 1 || out_vld !== 1'b0)
         $display("FAIL bp_release: got handshakes=%0d vld=%b, required 1 0", hs_cnt - hs0, out_vld);
      else n_pass++;
   endtask

   task automatic test_head_of_line();
      bit bad = 0;
      int hs0;
      apply_reset(16'hFFFF);
      out_rdy = 1'b1;
      gvt = 16'd5;
      push_rec(16'd8, 32'h8);
      push_rec(16'd2, 32'h2);
      hs0 = hs_cnt;
      for (int i = 0; i < 5; i++) begin
         if (out_vld !== 1'b0) bad = 1;
         tick();
      end
      n_total++;
      if (bad || count !== 5'd2)
         $display("FAIL hol_blocked: got early commit=%0d count=%0d, required 0 2", bad, count);
      else n_pass++;
      gvt = 16'd9;
      for (int i = 0; i < 10 && (hs_cnt - hs0) < 2; i++) tick();
      n_total++;
      if (hs_cnt - hs0 !== 2) $display("FAIL hol_release: got handshakes=%0d, required 2", hs_cnt - hs0);
      else n_pass++;
   endtask

   task automatic test_wrap();
      bit bad = 0;
      apply_reset(16'hFFFF);
      out_rdy = 1'b1;
      gvt = 16'h8000;
      in_vld = 1'b1; in_time = 16'd1; in_data = 32'hC000_0000;
      sb.push_back('{t: in_time, d: in_data});
      tick();
      for (int i = 1; i <= 40; i++) begin
         in_time = 16'(i + 1);
         in_data = 32'hC000_0000 | 32'(i);
         if (in_rdy !== 1'b1) bad = 1;
         else sb.push_back('{t: in_time, d: in_data});
         tick();
         if (count !== 5'd1) bad = 1;
      end
      in_vld = 1'b0;
      n_total++;
      if (bad) $display("FAIL wrap_steady: count left 1 or in_rdy dropped, got count=%0d, required 1", count);
      else n_pass++;
      for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
      tick();
      n_total++;
      if (sb.size() != 0 || count !== 5'd0)
         $display("FAIL wrap_drain: got pending=%0d count=%0d, required 0 0", sb.size(), count);
      else n_pass++;
   endtask

   task automatic test_done();
      apply_reset(16'd100);
      out_rdy = 1'b1;
      gvt = 16'd50;
      push_rec(16'd10, 32'hD0);
      for (int i = 0; i < 10 && (sb.size() != 0 || out_vld); i++) tick();
      tick();
      n_total++;
      if (done !== 1'b0 || count !== 5'd0)
         $display("FAIL done_early: got done=%b count=%0d, required 0 0", done, count);
      else n_pass++;
      gvt = 16'd100;
      tick();
      n_total++;
      if (done !== 1'b1 || in_rdy !== 1'b0)
         $display("FAIL done_set: got done=%b in_rdy=%b, required 1 0", done, in_rdy);
      else n_pass++;
      gvt = 16'd20;
      tick(); tick(); tick();
      n_total++;
      if (done !== 1'b1) $display("FAIL done_sticky: got %b, required 1", done);
      else n_pass++;
   endtask

   task automatic test_reset_mid_commit();
      apply_reset(16'hFFFF);
      gvt = 16'd10;
      push_rec(16'd3, 32'h77);
      tick();
      n_total++;
      if (out_vld !== 1'b1) $display("FAIL midrst_setup: got vld=%b, required 1", out_vld);
      else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (out_vld !== 1'b0 || count !== 5'd0)
         $display("FAIL midrst_async: got vld=%b count=%0d, required 0 0", out_vld, count);
      else n_pass++;
      sb.delete();
      tick();
      rst_n = 1'b1;
      out_rdy = 1'b1;
      tick(); tick();
      n_total++;
      if (out_vld !== 1'b0 || count !== 5'd0)
         $display("FAIL midrst_after: got vld=%b count=%0d, required 0 0", out_vld, count);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill();
      test_backpressure();
      test_head_of_line();
      test_wrap();
      test_done();
      test_reset_mid_commit();
      n_total++;
      if (sb.size() != 0) $display("FAIL scoreboard_leftover: got %0d pending, required 0", sb.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/gvt_commit_unit.md
Name: gvt_commit_unit

Overview:
- Downstream consumer of the GVT monitor's gvt output.
- Buffers processed-event history records pushed by the core array, in push order.
- Retires each record to the memory-writeback path once its timestamp is strictly below GVT, using a valid/ready handshake.
- Raises a sticky done flag once GVT reaches the simulation end time and all history has drained.

Parameters:
- TIME_WID, 16: timestamp width; must match the GVT monitor.
- DATA_WID, 32: event payload width.
- DEPTH, 16: history buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- gvt  in  TIME_WID  current GVT from the monitor; 0 after reset.
- end_time  in  TIME_WID  simulation end timestamp; static while running.
- in_vld  in  1  history record valid.
- in_rdy  out  1  buffer can accept a record.
- in_time  in  TIME_WID  record timestamp.
- in_data  in  DATA_WID  record payload.
- out_vld  out  1  committed record valid.
- out_rdy  in  1  writeback accepts the record.
- out_time  out  TIME_WID  committed timestamp.
- out_data  out  DATA_WID  committed payload.
- count  out  $clog2(DEPTH)+1  records held in the buffer, excluding the output register.
- done  out  1  simulation complete; sticky.

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is asynchronous and active-low.
- Reset values: pointers = 0, count = 0, out_vld = 0, out_time = 0, out_data = 0, done = 0, state = IDLE.
- Storage: circular buffer of DEPTH entries {time, data}, with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
- Push: occurs when in_vld && in_rdy. The record is written at tail and tail increments.
- in_rdy = (count < DEPTH) && !done. There is no bypass: in_rdy is low when full, even if a load happens in the same cycle.
- Output register: out_vld/out_time/out_data are registered.
- Load condition: (!out_vld || out_rdy) && count > 0 && head.time < gvt. The comparison is unsigned and strict.
- On load:
  - the head entry is copied into the output register;
  - out_vld is set to 1;
  - head increments.
- If out_vld && out_rdy and no load occurs, out_vld clears.
- Throughput: one record per cycle when out_rdy is held high and successive heads are committable.
- Head-of-line ordering: only the head entry is tested. A younger record behind an uncommittable head waits. Records are retired strictly in push order.
- Latency: a record pushed into an empty buffer, with gvt already above its time and out_rdy = 1, shows out_vld high after the second rising edge following the push.
- count is updated as +1 on push, -1 on load, and unchanged when both happen in the same cycle.
- Output stability: while out_vld && !out_rdy, out_time/out_data hold steady. A change in gvt must not alter a presented record.
- FSM:
  - IDLE: out_vld = 0. Go to COMMIT on load. Go to DONE when gvt >= end_time && count == 0 && !in_vld.
  - COMMIT: out_vld = 1. Stay in COMMIT on handshake plus load. Go to IDLE on handshake without load. Hold when there is no handshake.
  - DONE: done = 1 and in_rdy = 0. Exit only through rst_n.
- GVT regression: a decrease in gvt between cycles is tolerated. It only blocks further loads.
- Reset mid-operation: buffer contents are discarded, a pending out_vld drops immediately, and no partial handshake is completed.

Optional Feature:
- Macro: GVT_COMMIT_STATS_EN.
- When defined, two extra outputs are added:
  - commit_cnt, 32 bits: increments on each out_vld && out_rdy.
  - stall_cnt, 32 bits: increments each cycle where count > 0, the output register is free or draining, and head.time >= gvt.
- Both counters saturate at all ones and reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset release with gvt = 0, then push time = 5, data = 0xA: count goes to 1 and out_vld stays 0 indefinitely. Raise gvt to 6: out_vld = 1, out_time = 5, out_data = 0xA, and count returns to 0.
- Fill 16 records with times 1..16 and gvt = 0: the 16th push is accepted and in_rdy then drops with count = 16. Set gvt = 0xFFFF with out_rdy = 1: times 1..16 emerge on 16 consecutive cycles.
- Backpressure: hold out_rdy = 0 with record time = 3 presented, then change gvt 10 -> 2: out_time stays 3 and out_vld stays 1. Release out_rdy: exactly one handshake occurs.
- Head-of-line: push times 8 then 2 and set gvt = 5: nothing retires. Set gvt = 9: 8 retires, then 2.
- Wrap and simultaneous events: run 40 push/pop pairs with count held at 1 and simultaneous push plus load: count stays constant, pointers wrap, and data order is preserved.
- Done: end_time = 100, buffer drained, gvt = 100, in_vld = 0: done = 1 on the next edge, in_rdy = 0, and done persists after gvt drops. Assert rst_n low mid-commit: out_vld = 0 asynchronously.
